// File: rtl/vector_chip_pkg.sv
// ============================================================================
// vector_chip_pkg : chip-wide defaults and the port-index type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vector_chip_pkg;
  localparam int VC_NUM_PORTS  = 8;
  localparam int VC_DATA_W     = 64;
  localparam int VC_PORT_IDX_W = $clog2(VC_NUM_PORTS);

  typedef logic [VC_PORT_IDX_W-1:0] port_idx_t;
endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with occupancy count; storage is not reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-2 depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/port_request_buffer.sv
// ============================================================================
// port_request_buffer : per-port FIFOs feeding an external arbiter; the granted
// head is moved into a single output register. Revision: 1.0
// ============================================================================
`default_nettype none

module port_request_buffer
  import vector_chip_pkg::*;
#(
  parameter int NUM_PORTS = VC_NUM_PORTS,
  parameter int DATA_W    = VC_DATA_W,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [NUM_PORTS-1:0]          request_vector,
  input  logic [NUM_PORTS-1:0]          grant,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(NUM_PORTS)-1:0]  out_port,
  input  logic                          out_ready,
  output logic                          grant_err
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] nonzero;
  logic [NUM_PORTS-1:0] pop;
  logic [DATA_W-1:0]    head [NUM_PORTS];
  logic                 out_free;
  logic                 grant_onehot;
  logic                 grant_legal;
  logic                 grant_bad;
  logic [DATA_W-1:0]    sel_data;
  logic [PW-1:0]        sel_port;

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      logic [CW-1:0] count;

      sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid[i] & in_ready[i]),
        .pop       (pop[i]),
        .push_data (in_data[i*DATA_W +: DATA_W]),
        .data      (head[i]),
        .count     (count),
        .full      (full[i]),
        .empty     (empty[i])
      );

      assign nonzero[i]  = (count != '0);
      assign in_ready[i] = ~full[i];
      assign pop[i]      = grant_legal & grant[i] & ~empty[i];
    end
  endgenerate

  assign out_free       = ~out_valid | out_ready;
  assign request_vector = nonzero & {NUM_PORTS{out_free}};

  // Legal only when one-hot and aimed at a port currently requesting.
  assign grant_onehot = (grant != '0) && ((grant & (grant - NUM_PORTS'(1))) == '0);
  assign grant_legal  = grant_onehot && ((grant & ~request_vector) == '0);
  assign grant_bad    = (grant != '0) && !grant_legal;

  always_comb begin
    sel_data = '0;
    sel_port = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | head[i];
        sel_port = sel_port | PW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
      grant_err <= 1'b0;
    end else begin
      if (grant_legal) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_port  <= sel_port;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (grant_bad) grant_err <= 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: doc/port_request_buffer.md
PORT_REQUEST_BUFFER -- requirements
Module: port_request_buffer

Interface
REQ-001 Parameters SHALL be: NUM_PORTS, default 8, number of requesting ports; DATA_W, default 64, payload width; DEPTH, default 4, entries per port FIFO, power of 2 and at least 2.
REQ-002 clk, input, 1, sole clock; all state changes occur on the rising edge.
REQ-003 rst_n, input, 1, asynchronous active-low reset.
REQ-004 in_valid, input, NUM_PORTS, per-port push request.
REQ-005 in_data, input, NUM_PORTS*DATA_W, per-port payload; port i occupies bits [i*DATA_W +: DATA_W].
REQ-006 in_ready, output, NUM_PORTS, per-port space available.
REQ-007 request_vector, output, NUM_PORTS, pending-request bits sent to the downstream priority arbiter.
REQ-008 grant, input, NUM_PORTS, one-hot combinational grant returned by the arbiter.
REQ-009 out_valid, output, 1, output register holds a payload.
REQ-010 out_data, output, DATA_W, granted payload.
REQ-011 out_port, output, $clog2(NUM_PORTS), source port index of out_data.
REQ-012 out_ready, input, 1, consumer accepts the output register.
REQ-013 grant_err, output, 1, sticky flag set when grant is illegal.

Function
REQ-014 Each port SHALL own an independent FIFO of DEPTH entries with a count of width $clog2(DEPTH)+1.
REQ-015 Port i SHALL drive in_ready[i] = (count_i < DEPTH); a push SHALL occur when in_valid[i] & in_ready[i] are both high at a clock edge.
REQ-016 Full FIFO: in_ready SHALL stay low even if a pop occurs in the same cycle (no full-bypass).
REQ-017 Output register free: out_free SHALL be defined as (!out_valid | out_ready).
REQ-018 request_vector[i] SHALL equal (count_i != 0) & out_free, combinationally.
REQ-019 A grant SHALL be legal when it is one-hot and the granted bit is set in request_vector; only a legal grant SHALL pop the granted FIFO head into out_data/out_port and set out_valid at the same edge.
REQ-020 An illegal grant (multi-hot, or a bit on a non-requesting port) SHALL cause no pop and no output load, and SHALL set grant_err, which stays set until reset.
REQ-021 grant == 0 SHALL cause no action.
REQ-022 When out_valid & out_ready and no legal grant occur, out_valid SHALL clear at the next edge.
REQ-023 A simultaneous push and pop on the same non-full port SHALL leave count unchanged and preserve FIFO order.
REQ-024 Latency: a word pushed into an empty port at edge N SHALL be requestable in cycle N+1 and SHALL appear on out_valid after edge N+1, given a legal grant and out_free. Throughput SHALL be one word per cycle when out_ready is held high.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 out_data and out_port SHALL hold stable while out_valid & !out_ready.

Reset
REQ-027 While rst_n is low: all counts and pointers 0; out_valid 0; out_data 0; out_port 0; grant_err 0; in_ready all-ones; request_vector 0.
REQ-028 Reset asserted mid-operation SHALL discard all queued and output data immediately, without waiting for a clock edge.
REQ-029 FIFO storage arrays SHALL NOT be reset.

Structure
REQ-030 NUM_PORTS and DATA_W defaults, and the port-index typedef, SHALL live in the shared vector_chip_pkg.
REQ-031 The per-port queue SHALL be one sub-module, sync_fifo (push, pop, data, count, full, empty), instantiated NUM_PORTS times via generate.
REQ-032 The block SHALL instantiate no arbiter; it connects externally to the priority arbiter's request_vector and grant ports.

Verification
REQ-033 Push 0xA1 on port 3 only, with the arbiter connected and out_ready=1 -> request_vector=8'h08 one cycle later; out_valid=1, out_data=0xA1, out_port=3 on the following cycle.
REQ-034 Ports 1 and 5 each hold one word, out_ready=1 -> port 1 drains first, then port 5 on the next cycle, with no idle cycle between them.
REQ-035 Push 4 words to port 0 with no grant -> in_ready[0]=0; a fifth push is ignored; after the 4 words drain, they emerge in order and count returns to 0.
REQ-036 Hold out_ready=0 with out_valid=1 -> request_vector=0 and out_data stable for 10 cycles; releasing out_ready resumes draining.
REQ-037 Force grant=8'h06 -> no pop occurs, grant_err=1, and grant_err stays 1 until rst_n is pulsed.
REQ-038 Assert rst_n low mid-burst with 3 ports non-empty -> all outputs reach their reset values asynchronously; after release, no stale data appears.
